// File: rtl/rpi_gpio_tx.sv
// rpi_gpio_tx: transmit side of the 8-bit Raspberry Pi GPIO link.
// Buffers filtered samples in a FIFO. Each word goes out over a 4-phase
// req/ack handshake. The asynchronous ack is synchronized before use, and
// each handshake phase is guarded by a timeout. Overflow and timeout are
// reported as sticky flags.
module rpi_gpio_tx #(
    parameter int unsigned FIFO_DEPTH  = 16,
    parameter int unsigned TIMEOUT_CYC = 1023,
    parameter int unsigned CNT_W       = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sample_in,
    input  logic             sample_valid,
    input  logic             clr_flags,
    input  logic             rpi_ack_i,
    output logic [7:0]       rpi_gpio_tx_o,
    output logic             rpi_req_o,
    output logic             fifo_full,
    output logic [CNT_W-1:0] fifo_count,
    output logic             overflow,
    output logic             timeout_err
);

    localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
    localparam int unsigned TMR_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(TIMEOUT_CYC);

    typedef enum logic [1:0] {StIdle, StSetup, StReq, StRel} state_e;

    // Storage and state registers
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic [7:0]       r_data;
    logic             r_req;
    logic [TMR_W-1:0] r_timer;
    logic             r_rel_to;  // REL timeout already reported for this phase
    logic             r_ack_meta;
    logic             r_ack_s;
    logic             r_overflow;
    logic             r_timeout;
    state_e           r_state;

    // Combinational next-state signals
    state_e           w_state_d;
    logic             w_req_d;
    logic [TMR_W-1:0] w_timer_d;
    logic             w_rel_to_d;
    logic             w_pop;
    logic             w_to_evt;
    logic             w_full;
    logic             w_push;

    // Full check uses the pre-edge count, so a pop on the same edge cannot rescue a write
    assign w_full = (r_count == DEPTH_C);
    assign w_push = sample_valid && !w_full;

    // Two-flop synchronizer for the asynchronous ack
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack_meta <= 1'b0;
            r_ack_s    <= 1'b0;
        end else begin
            r_ack_meta <= rpi_ack_i;
            r_ack_s    <= r_ack_meta;
        end
    end

    // FIFO storage write; contents need no reset since the pointers/count gate visibility
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= sample_in;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            unique case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Handshake FSM next-state, request and phase-timer logic
    always_comb begin
        w_state_d  = r_state;
        w_req_d    = r_req;
        w_timer_d  = r_timer;
        w_rel_to_d = r_rel_to;
        w_pop      = 1'b0;
        w_to_evt   = 1'b0;
        unique case (r_state)
            StIdle: begin
                w_req_d = 1'b0;
                if (r_count != '0) begin
                    w_pop     = 1'b1;
                    w_state_d = StSetup;
                end
            end
            StSetup: begin
                // Data has been on the bus for one cycle; raise req now
                w_req_d   = 1'b1;
                w_timer_d = '0;
                w_state_d = StReq;
            end
            StReq: begin
                if (r_ack_s) begin
                    w_req_d    = 1'b0;
                    w_timer_d  = '0;
                    w_rel_to_d = 1'b0;
                    w_state_d  = StRel;
                end else if (r_timer == TMR_MAX) begin
                    // Word is abandoned, not retried
                    w_to_evt   = 1'b1;
                    w_req_d    = 1'b0;
                    w_timer_d  = '0;
                    w_rel_to_d = 1'b0;
                    w_state_d  = StRel;
                end else begin
                    w_timer_d = r_timer + TMR_W'(1);
                end
            end
            StRel: begin
                if (!r_ack_s) begin
                    w_state_d = StIdle;
                end else if (r_timer == TMR_MAX) begin
                    // No forced exit while ack stays high; flag only once per phase
                    if (!r_rel_to) begin
                        w_to_evt   = 1'b1;
                        w_rel_to_d = 1'b1;
                    end
                end else begin
                    w_timer_d = r_timer + TMR_W'(1);
                end
            end
            default: begin
                w_req_d   = 1'b0;
                w_state_d = StIdle;
            end
        endcase
    end

    // FSM state, bus data and handshake registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= StIdle;
            r_req    <= 1'b0;
            r_timer  <= '0;
            r_rel_to <= 1'b0;
            r_data   <= '0;
        end else begin
            r_state  <= w_state_d;
            r_req    <= w_req_d;
            r_timer  <= w_timer_d;
            r_rel_to <= w_rel_to_d;
            if (w_pop) begin
                r_data <= r_mem[r_rd_ptr];
            end
        end
    end

    // Sticky error flags; a set event beats a simultaneous clear
    always_ff @(posedge clk) begin
        if (rst) begin
            r_overflow <= 1'b0;
            r_timeout  <= 1'b0;
        end else begin
            if (sample_valid && w_full) begin
                r_overflow <= 1'b1;
            end else if (clr_flags) begin
                r_overflow <= 1'b0;
            end
            if (w_to_evt) begin
                r_timeout <= 1'b1;
            end else if (clr_flags) begin
                r_timeout <= 1'b0;
            end
        end
    end

    assign rpi_gpio_tx_o = r_data;
    assign rpi_req_o     = r_req;
    assign fifo_full     = w_full;
    assign fifo_count    = r_count;
    assign overflow      = r_overflow;
    assign timeout_err   = r_timeout;

endmodule

// File: tb/tb_rpi_gpio_tx.sv
// Self-checking bench for rpi_gpio_tx: directed scenarios plus randomized
// batches checked against a queue-based reference of the words sent.
module tb_rpi_gpio_tx;

    localparam int unsigned DEPTH = 16;
    localparam int unsigned TOUT  = 64;
    localparam int unsigned CW    = 5;

    localparam int PI_AUTO  = 0;  // ack after a delay, release after req drops
    localparam int PI_LOW   = 1;  // never ack
    localparam int PI_STUCK = 2;  // ack, then never release

    logic          clk;
    logic          rst;
    logic [7:0]    sample_in;
    logic          sample_valid;
    logic          clr_flags;
    logic          rpi_ack_i;
    logic [7:0]    rpi_gpio_tx_o;
    logic          rpi_req_o;
    logic          fifo_full;
    logic [CW-1:0] fifo_count;
    logic          overflow;
    logic          timeout_err;

    int total;
    int bad;

    int pi_mode;
    int pi_lo;
    int pi_hi;

    logic [7:0] rx_q[$];   // words seen on the bus at each req rise
    logic [7:0] exp_q[$];  // words the reference expects to be sent

    rpi_gpio_tx #(
        .FIFO_DEPTH (DEPTH),
        .TIMEOUT_CYC(TOUT),
        .CNT_W      (CW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .clr_flags    (clr_flags),
        .rpi_ack_i    (rpi_ack_i),
        .rpi_gpio_tx_o(rpi_gpio_tx_o),
        .rpi_req_o    (rpi_req_o),
        .fifo_full    (fifo_full),
        .fifo_count   (fifo_count),
        .overflow     (overflow),
        .timeout_err  (timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pi model: drives ack on falling edges
    initial begin : pi_model
        int ack_wait;
        int pi_delay;
        ack_wait  = 0;
        pi_delay  = 0;
        rpi_ack_i = 1'b0;
        forever begin
            @(negedge clk);
            if (pi_mode == PI_LOW) begin
                rpi_ack_i = 1'b0;
                ack_wait  = 0;
            end else if (rpi_req_o && !rpi_ack_i) begin
                if (ack_wait == 0) pi_delay = $urandom_range(pi_hi, pi_lo);
                if (ack_wait >= pi_delay) begin
                    rpi_ack_i = 1'b1;
                    ack_wait  = 0;
                end else begin
                    ack_wait++;
                end
            end else if (!rpi_req_o && rpi_ack_i && pi_mode == PI_AUTO) begin
                rpi_ack_i = 1'b0;
            end
        end
    end

    // Bus monitor: capture the data word at every req rise
    initial begin : monitor
        logic req_prev;
        req_prev = 1'b0;
        forever begin
            @(posedge clk);
            #2;
            if (rpi_req_o && !req_prev) rx_q.push_back(rpi_gpio_tx_o);
            req_prev = rpi_req_o;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp)
        else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input logic [7:0] b);
        sample_in    = b;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input logic level, input int budget, input string tag);
        int k;
        k = 0;
        while (rpi_req_o !== level && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(rpi_req_o), 32'(level));
    endtask

    task automatic wait_rx(input int n, input int budget, input string tag);
        int k;
        k = 0;
        while (rx_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        check(tag, 32'(rx_q.size()), 32'(n));
    endtask

    initial begin : main
        int base;
        int n;
        int len;
        int req_seen;
        logic [7:0] b;

        total        = 0;
        bad          = 0;
        rst          = 1'b1;
        sample_in    = '0;
        sample_valid = 1'b0;
        clr_flags    = 1'b0;
        pi_mode      = PI_AUTO;
        pi_lo        = 3;
        pi_hi        = 3;

        // Reset state
        tick();
        tick();
        check("rst_bus", 32'(rpi_gpio_tx_o), 32'h0);
        check("rst_req", 32'(rpi_req_o), 32'h0);
        check("rst_cnt", 32'(fifo_count), 32'h0);
        check("rst_full", 32'(fifo_full), 32'h0);
        check("rst_ovf", 32'(overflow), 32'h0);
        check("rst_tout", 32'(timeout_err), 32'h0);
        rst = 1'b0;
        tick();

        // Single word: latency and req release timing
        base = rx_q.size();
        write_word(8'hA5);
        check("sw_cnt_n", 32'(fifo_count), 32'h1);
        check("sw_req_n", 32'(rpi_req_o), 32'h0);
        tick();
        check("sw_bus_n1", 32'(rpi_gpio_tx_o), 32'hA5);
        check("sw_req_n1", 32'(rpi_req_o), 32'h0);
        tick();
        check("sw_req_n2", 32'(rpi_req_o), 32'h1);
        n = 0;
        while (!rpi_ack_i && n < 50) begin
            tick();
            n++;
        end
        check("sw_ack_seen", 32'(rpi_ack_i), 32'h1);
        check("sw_req_e0", 32'(rpi_req_o), 32'h1);
        tick();
        check("sw_req_e1", 32'(rpi_req_o), 32'h1);
        tick();
        check("sw_req_e2", 32'(rpi_req_o), 32'h0);
        repeat (8) tick();
        check("sw_cnt_end", 32'(fifo_count), 32'h0);
        check("sw_req_end", 32'(rpi_req_o), 32'h0);
        check("sw_rx_n", 32'(rx_q.size()), 32'(base + 1));
        if (rx_q.size() > base) check("sw_rx_word", 32'(rx_q[base]), 32'hA5);

        // Burst of 16 back-to-back words with a responsive Pi
        pi_lo = 0;
        pi_hi = 2;
        base  = rx_q.size();
        for (int i = 0; i < 16; i++) begin
            sample_in    = 8'(i + 1);
            sample_valid = 1'b1;
            tick();
            if (i >= 1) check("burst_not_full", 32'(fifo_full), 32'h0);
        end
        sample_valid = 1'b0;
        wait_rx(base + 16, 16 * 40, "burst_rx_n");
        for (int i = 0; i < 16; i++) begin
            if (rx_q.size() > base + i) check("burst_word", 32'(rx_q[base + i]), 32'(i + 1));
        end
        check("burst_ovf", 32'(overflow), 32'h0);

        // Overflow: Pi stalled, 18 words offered
        pi_mode = PI_LOW;
        do_reset();
        for (int i = 0; i < 18; i++) begin
            sample_in    = 8'(8'h80 + i);
            sample_valid = 1'b1;
            tick();
            if (i == 16) begin
                check("ovf_full17", 32'(fifo_full), 32'h1);
                check("ovf_cnt17", 32'(fifo_count), 32'd16);
                check("ovf_flag17", 32'(overflow), 32'h0);
            end
        end
        check("ovf_flag18", 32'(overflow), 32'h1);
        check("ovf_cnt18", 32'(fifo_count), 32'd16);
        clr_flags = 1'b1;
        tick();
        check("ovf_set_wins", 32'(overflow), 32'h1);
        sample_valid = 1'b0;
        tick();
        clr_flags = 1'b0;
        check("ovf_cleared", 32'(overflow), 32'h0);

        // Reset mid-handshake with 3 words queued
        do_reset();
        for (int i = 0; i < 4; i++) write_word(8'(8'h31 + i));
        check("mr_req_pre", 32'(rpi_req_o), 32'h1);
        check("mr_cnt_pre", 32'(fifo_count), 32'h3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mr_req", 32'(rpi_req_o), 32'h0);
        check("mr_bus", 32'(rpi_gpio_tx_o), 32'h0);
        check("mr_cnt", 32'(fifo_count), 32'h0);
        req_seen = 0;
        repeat (6) begin
            tick();
            if (rpi_req_o) req_seen++;
        end
        check("mr_idle", 32'(req_seen), 32'h0);

        // Timeout in REQ: word abandoned, next word sent
        base = rx_q.size();
        write_word(8'h11);
        write_word(8'h22);
        wait_req(1'b1, 10, "to_req_up");
        n = 0;
        while (!timeout_err && n < 3 * TOUT) begin
            tick();
            n++;
        end
        check("to_window", 32'(n >= TOUT && n <= TOUT + 2), 32'h1);
        check("to_req_low", 32'(rpi_req_o), 32'h0);
        wait_req(1'b1, 20, "to_next_req");
        check("to_next_bus", 32'(rpi_gpio_tx_o), 32'h22);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        check("to_cleared", 32'(timeout_err), 32'h0);

        // Ack stuck high in REL
        pi_mode = PI_STUCK;
        pi_lo   = 1;
        pi_hi   = 1;
        do_reset();
        base = rx_q.size();
        write_word(8'h5A);
        write_word(8'h6B);
        wait_req(1'b1, 10, "st_req_up");
        wait_req(1'b0, 30, "st_req_down");
        n = 0;
        while (!timeout_err && n < 3 * TOUT) begin
            tick();
            n++;
        end
        check("st_window", 32'(n >= TOUT && n <= TOUT + 2), 32'h1);
        req_seen = 0;
        repeat (2 * TOUT) begin
            tick();
            if (rpi_req_o) req_seen++;
        end
        check("st_no_req", 32'(req_seen), 32'h0);
        check("st_cnt", 32'(fifo_count), 32'h1);
        clr_flags = 1'b1;
        tick();
        clr_flags = 1'b0;
        repeat (TOUT + 10) tick();
        check("st_once", 32'(timeout_err), 32'h0);
        pi_mode = PI_AUTO;
        wait_rx(base + 2, 60, "st_resume_n");
        if (rx_q.size() >= base + 2) begin
            check("st_word0", 32'(rx_q[base]), 32'h5A);
            check("st_word1", 32'(rx_q[base + 1]), 32'h6B);
        end

        // Randomized batches against the queue reference
        pi_lo = 0;
        pi_hi = 6;
        do_reset();
        for (int batch = 0; batch < 4; batch++) begin
            base = rx_q.size();
            exp_q.delete();
            len = $urandom_range(15, 1);
            for (int i = 0; i < len; i++) begin
                b = 8'($urandom);
                exp_q.push_back(b);
                write_word(b);
                repeat ($urandom_range(3, 0)) tick();
            end
            wait_rx(base + len, len * 40, "rnd_rx_n");
            for (int i = 0; i < len; i++) begin
                if (rx_q.size() > base + i) check("rnd_word", 32'(rx_q[base + i]), 32'(exp_q[i]));
            end
        end
        repeat (20) tick();
        check("rnd_cnt", 32'(fifo_count), 32'h0);
        check("rnd_ovf", 32'(overflow), 32'h0);
        check("rnd_tout", 32'(timeout_err), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/rpi_gpio_tx.md
Name: rpi_gpio_tx

Overview:
- Transmit side of the 8-bit Raspberry Pi GPIO link. The moving-average filter produces averaged price samples, and this block returns them to the Pi.
- Samples are buffered in a small FIFO. Each one is sent as one word over an 8-bit parallel bus using a 4-phase req/ack handshake.
- The Pi's ack is asynchronous. The block synchronizes it, detects a stalled handshake with a timeout, and reports overflow and timeout as sticky flags.

Parameters:
- FIFO_DEPTH, 16: FIFO word count. Power of 2, minimum 2.
- TIMEOUT_CYC, 1023: clk cycles allowed per handshake phase before a timeout error. Minimum 8.
- CNT_W, 5: width of fifo_count. Must equal log2(FIFO_DEPTH)+1.

Ports:
- clk  in  1  system clock; all logic on its rising edge.
- rst  in  1  reset; synchronous, active-high.
- sample_in  in  8  filtered sample to send.
- sample_valid  in  1  one-cycle write strobe for sample_in.
- clr_flags  in  1  clears overflow and timeout_err.
- rpi_ack_i  in  1  ack from the Pi; asynchronous.
- rpi_gpio_tx_o  out  8  data bus to the Pi.
- rpi_req_o  out  1  request strobe to the Pi.
- fifo_full  out  1  high when count == FIFO_DEPTH.
- fifo_count  out  CNT_W  number of words in the FIFO.
- overflow  out  1  sticky: a write was dropped.
- timeout_err  out  1  sticky: a handshake phase timed out.

Behaviour:
Reset:
- On any edge with rst=1, all outputs go to 0: rpi_gpio_tx_o, rpi_req_o, fifo_count, fifo_full, overflow, timeout_err.
- The FIFO is emptied, the FSM returns to IDLE, and both ack synchronizer flops are cleared.
- Reset applied mid-handshake drops the in-flight word; req is 0 on the next edge.

Ack synchronizer:
- rpi_ack_i passes through 2 flops to give ack_s.
- ack_s lags the pin by 2 edges. The FSM uses only ack_s.

FIFO write:
- On sample_valid=1 with count < FIFO_DEPTH before the edge, the word is stored and count increments.
- On sample_valid=1 with count == FIFO_DEPTH before the edge, the word is dropped and overflow is set.
- The full check uses the pre-edge count, so a write at full is dropped even if a pop occurs the same edge.
- Simultaneous push and pop when not full: count is unchanged and both take effect.
- Pointers wrap modulo FIFO_DEPTH.

FSM:
- IDLE: req=0. When count > 0, pop the head word into rpi_gpio_tx_o and go to SETUP.
- SETUP: data is held for one cycle of setup time. Next edge: req=1, timer=0, go to REQ.
- REQ: wait for ack_s=1.
  - On ack_s=1: req=0, timer=0, go to REL.
  - If timer reaches TIMEOUT_CYC: set timeout_err, req=0, timer=0, go to REL. The word is lost and is not retried.
- REL: wait for ack_s=0.
  - On ack_s=0: go to IDLE.
  - If timer reaches TIMEOUT_CYC: set timeout_err once and stay in REL; there is no forced exit while ack stays high.
- The timer increments every cycle in REQ and REL, and saturates.
- rpi_gpio_tx_o holds its value from SETUP until the next pop. It is stable for the whole time req=1.

Latency and throughput:
- A write at edge N into an empty FIFO with the FSM in IDLE: count=1 after N, data on the bus after N+1, req=1 after N+2.
- Minimum handshake with ack returned immediately is about 8 cycles per word.

Flags:
- overflow and timeout_err hold until clr_flags=1 or rst=1.
- If clr_flags and a new set event occur on the same edge, the set wins.

Arithmetic: fifo_count never exceeds FIFO_DEPTH and never underflows.

Test Plan:
- Single word: reset, write 0xA5 at edge N, bench acks 3 cycles after req rises → bus=0xA5 after N+1; req=1 after N+2; req falls 2 edges after the ack rises; FSM back in IDLE after ack falls; count ends at 0.
- Burst order: write 0x01..0x10 back-to-back (16 words, FIFO_DEPTH=16) with a responsive Pi model → 16 handshakes carrying 0x01..0x10 in order; fifo_full=0 after the first pop; overflow=0.
- Overflow: hold ack=0, write 18 words → fifo_full=1 once count=16 (the first word has been popped into the handshake, so words 1–17 are accepted). Word 18 is dropped, overflow=1. With clr_flags=1 and sample_valid=1 on the same edge at full → overflow stays 1.
- Timeout: ack never asserted → timeout_err=1 after TIMEOUT_CYC cycles in REQ; req=0; the next word is sent. A later clr_flags=1 clears timeout_err to 0.
- Reset mid-handshake: assert rst for 1 cycle while req=1 with 3 words queued → on the next edge req=0, bus=0x00, fifo_count=0, FSM in IDLE.
- Ack stuck high in REL: after a normal ack, hold ack=1 → timeout_err=1 after TIMEOUT_CYC; no new req while ack stays 1; releasing ack resumes transmission.
